// File: rtl/zigzag_bram_reader.sv
`default_nettype none
// ============================================================================
// zigzag_bram_reader: streams 64-coef blocks out of a 4-slot BRAM ring through
// a 2-entry skid FIFO. Define ZZ_REORDER_EN for JPEG zig-zag read order.
// Rev 1.0
// ============================================================================
module zigzag_bram_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  output logic        ce_BRAM_read,
  output logic [7:0]  addr_BRAM_read,
  input  logic [11:0] dout_BRAM,
  output logic [11:0] coef,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic        coef_last,
  output logic        blk_done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_k;
  logic [1:0]  r_blk_idx;
  logic [7:0]  r_addr;
  logic        r_blk_done;
  logic [2:0]  r_pending;
  logic        r_overflow;
  logic        r_inflight;
  logic        r_inflight_last;
  logic [11:0] r_fifo_data [2];
  logic [1:0]  r_fifo_last;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_issue;
  logic        w_avail;
  logic        w_accept;
  logic [2:0]  w_occ;
  logic [5:0]  w_pos;
  logic [7:0]  w_rd_addr;

`ifdef ZZ_REORDER_EN
  localparam logic [5:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  assign w_pos = ZZ_TABLE[r_k];
`else
  assign w_pos = r_k;
`endif

  assign coef_valid = (r_count != 2'd0);
  assign coef       = r_fifo_data[r_rd_ptr];
  assign coef_last  = coef_valid & r_fifo_last[r_rd_ptr];
  assign blk_done   = r_blk_done;
  assign overflow   = r_overflow;

  assign w_pop     = coef_valid & coef_ready;
  // Credit check counts the slot freed by this cycle's pop so a full-rate
  // stream keeps one entry buffered and one read in flight.
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (r_state == S_READ) && (w_occ < 3'd2);
  assign w_rd_addr = {r_blk_idx, w_pos};
  assign w_avail   = (r_pending > {2'b00, r_blk_done});
  assign w_accept  = blk_valid && (r_pending != 3'd4);

  assign ce_BRAM_read   = w_issue;
  assign addr_BRAM_read = w_issue ? w_rd_addr : r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= 6'd0;
      r_blk_idx  <= 2'd0;
      r_addr     <= 8'd0;
      r_blk_done <= 1'b0;
    end else begin
      r_blk_done <= 1'b0;
      if (w_issue) begin
        r_addr <= w_rd_addr;
      end
      case (r_state)
        S_IDLE: begin
          if (w_avail) begin
            r_state <= S_READ;
            r_k     <= 6'd0;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (r_k == 6'd63) begin
              r_state <= S_DRAIN;
            end else begin
              r_k <= r_k + 6'd1;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && coef_last) begin
            r_blk_done <= 1'b1;
            r_blk_idx  <= r_blk_idx + 2'd1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending       <= 3'd0;
      r_overflow      <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data[0]  <= 12'd0;
      r_fifo_data[1]  <= 12'd0;
      r_fifo_last     <= 2'b00;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_k == 6'd63);
      if (blk_valid && (r_pending == 3'd4)) begin
        r_overflow <= 1'b1;
      end
      case ({w_accept, r_blk_done})
        2'b10:   r_pending <= r_pending + 3'd1;
        2'b01:   r_pending <= r_pending - 3'd1;
        default: r_pending <= r_pending;
      endcase
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= dout_BRAM;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_bram_reader.sv
`default_nettype none
// ============================================================================
// tb_zigzag_bram_reader: directed scenarios with random BRAM contents and
// random back-pressure, checked against a block-order reference model.
// Rev 1.0
// ============================================================================
module tb_zigzag_bram_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        blk_valid;
  logic        coef_ready;
  logic        ce;
  logic [7:0]  addr;
  logic [11:0] dout = 12'd0;
  logic [11:0] coef;
  logic        cvalid;
  logic        clast;
  logic        done;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int reads_total = 0;

  logic [11:0] mem [256];
  int          pos [64];
  logic [11:0] got_data [$];
  bit          got_last [$];
  int          got_cyc  [$];
  logic [7:0]  got_addr [$];
  int          ce_cyc   [$];

  logic        bram_en_q = 1'b0;
  logic [11:0] bram_data_q = 12'd0;

  zigzag_bram_reader dut (
    .clk            (clk),
    .rst            (rst),
    .blk_valid      (blk_valid),
    .ce_BRAM_read   (ce),
    .addr_BRAM_read (addr),
    .dout_BRAM      (dout),
    .coef           (coef),
    .coef_valid     (cvalid),
    .coef_ready     (coef_ready),
    .coef_last      (clast),
    .blk_done       (done),
    .overflow       (ovf)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // BRAM behaviour: read request seen mid-cycle, data registered on the edge
  always @(posedge clk) begin
    if (bram_en_q) dout <= bram_data_q;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: records reads and transfers, checks stall stability and credits
  initial begin
    int outstanding;
    bit prev_stall;
    bit prev_xfer_last;
    logic [11:0] prev_coef;
    bit prev_last;
    bit pop;
    outstanding = 0; prev_stall = 0; prev_xfer_last = 0; prev_coef = 0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 0; prev_stall = 0; prev_xfer_last = 0; bram_en_q = 1'b0;
      end else begin
        pop = cvalid && coef_ready;
        bram_en_q = ce;
        bram_data_q = mem[addr];
        if (ce) begin
          chk("ce_credit", ((outstanding - int'(pop)) < 2) ? 1 : 0, 1);
          got_addr.push_back(addr);
          ce_cyc.push_back(cyc);
          reads_total++;
        end
        if (prev_stall) begin
          chk("stall_coef", coef, prev_coef);
          chk("stall_last", clast, prev_last);
        end
        if (done) begin
          chk("done_after_last", prev_xfer_last, 1);
          done_cnt++;
        end
        if (pop) begin
          got_data.push_back(coef);
          got_last.push_back(clast);
          got_cyc.push_back(cyc);
        end
        outstanding = outstanding + int'(ce) - int'(pop);
        prev_stall = cvalid && !coef_ready;
        prev_coef = coef;
        prev_last = clast;
        prev_xfer_last = pop && clast;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ce"}, ce, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_coef"}, coef, 0);
    chk({tag, "_valid"}, cvalid, 0);
    chk({tag, "_last"}, clast, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  // Expected block b: coefficient k comes from slot b at position pos[k]
  task automatic check_block(input int b, input int d, input int a);
    for (int k = 0; k < 64; k++) begin
      if (d + k < got_data.size()) begin
        chk($sformatf("blk%0d_k%0d_data", b, k), got_data[d+k], mem[b*64 + pos[k]]);
        chk($sformatf("blk%0d_k%0d_last", b, k), got_last[d+k], (k == 63) ? 1 : 0);
      end else begin
        chk($sformatf("blk%0d_k%0d_missing", b, k), 0, 1);
      end
      if (a + k < got_addr.size())
        chk($sformatf("blk%0d_k%0d_addr", b, k), got_addr[a+k], b*64 + pos[k]);
      else
        chk($sformatf("blk%0d_k%0d_noread", b, k), 0, 1);
    end
  endtask

  task automatic pulse();
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: toggling, 2: random; chain re-pulses blk_valid on blk_done
  task automatic wait_done(input int n, input int mode, input bit chain_in);
    int target;
    bit chain;
    chain = chain_in;
    target = done_cnt + n;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      blk_valid = 1'b0;
      case (mode)
        0:       coef_ready = 1'b1;
        1:       coef_ready = ~coef_ready;
        default: coef_ready = 1'($urandom_range(0, 1));
      endcase
      if (chain && done) begin
        blk_valid = 1'b1;
        chain = 0;
      end
      if (done_cnt >= target) break;
    end
    chk("done_timeout", (done_cnt >= target) ? 1 : 0, 1);
    coef_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, nb, d0, a0, t0, r0, dc;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          pos[idx] = r*8 + (s - r); idx++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          pos[idx] = r*8 + (s - r); idx++;
        end
      end
    end
`ifndef ZZ_REORDER_EN
    for (int k = 0; k < 64; k++) pos[k] = k;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);

    rst = 1'b1; blk_valid = 1'b0; coef_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");

    // A: first pulse together with reset release, ready always high
    nb = 0;
    d0 = got_data.size(); a0 = got_addr.size(); t0 = cyc;
    rst = 1'b0;
    pulse();
    wait_done(1, 0, 0);
    chk("A_count", got_data.size() - d0, 64);
    check_block(nb, d0, a0);
    chk("A_valid_to_ce", ce_cyc[a0] - t0, 2);
    chk("A_read_to_valid", got_cyc[d0] - ce_cyc[a0], 2);
    chk("A_full_rate", got_cyc[d0+63] - got_cyc[d0], 63);
    nb = (nb + 1) % 4;

    // B: ready toggling every cycle
    d0 = got_data.size(); a0 = got_addr.size();
    pulse();
    wait_done(1, 1, 0);
    chk("B_count", got_data.size() - d0, 64);
    check_block(nb, d0, a0);
    nb = (nb + 1) % 4;

    // C: random back-pressure
    d0 = got_data.size(); a0 = got_addr.size();
    pulse();
    wait_done(1, 2, 0);
    chk("C_count", got_data.size() - d0, 64);
    check_block(nb, d0, a0);
    nb = (nb + 1) % 4;

    // D: new block announced in the same cycle the previous one is released
    d0 = got_data.size(); a0 = got_addr.size();
    pulse();
    wait_done(2, 0, 1);
    chk("D_count", got_data.size() - d0, 128);
    check_block(nb, d0, a0);
    check_block((nb + 1) % 4, d0 + 64, a0 + 64);
    nb = (nb + 2) % 4;
    r0 = reads_total;
    repeat (60) @(posedge clk);
    #1;
    chk("D_no_extra_reads", reads_total, r0);
    chk("D_ovf_clear", ovf, 0);

    // E: five announcements with the stream stalled
    d0 = got_data.size(); a0 = got_addr.size();
    coef_ready = 1'b0;
    blk_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    blk_valid = 1'b0;
    chk("E_ovf_set", ovf, 1);
    wait_done(4, 2, 0);
    chk("E_count", got_data.size() - d0, 256);
    for (int j = 0; j < 4; j++) check_block((nb + j) % 4, d0 + 64*j, a0 + 64*j);
    r0 = reads_total;
    repeat (80) @(posedge clk);
    #1;
    chk("E_no_fifth_block", reads_total, r0);
    chk("E_ovf_held", ovf, 1);

    // F: reset in the middle of a block
    d0 = got_data.size();
    pulse();
    for (int i = 0; i < 300 && (got_data.size() - d0) < 20; i++) begin
      @(posedge clk); #1;
    end
    chk("F_reached_20", ((got_data.size() - d0) >= 20) ? 1 : 0, 1);
    dc = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("F_no_partial_done", done_cnt, dc);
    d0 = got_data.size(); a0 = got_addr.size(); t0 = cyc;
    rst = 1'b0;
    pulse();
    wait_done(1, 2, 0);
    chk("F_count", got_data.size() - d0, 64);
    check_block(0, d0, a0);
    chk("F_valid_to_ce", ce_cyc[a0] - t0, 2);
    chk("F_ovf_cleared", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zigzag_bram_reader.md
ZIGZAG_BRAM_READER -- requirements
Module: zigzag_bram_reader

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: blk_valid  in  1  one-cycle pulse from the BRAM writer: one more 64-coef block complete in ring.
REQ-004 SHALL have port: ce_BRAM_read  out  1  BRAM read enable.
REQ-005 SHALL have port: addr_BRAM_read  out  8  BRAM read address {blk_idx[1:0], pos[5:0]}.
REQ-006 SHALL have port: dout_BRAM  in  12  BRAM read data, valid one cycle after ce_BRAM_read.
REQ-007 SHALL have port: coef  out  12  streamed coefficient.
REQ-008 SHALL have port: coef_valid  out  1  coef holds valid data.
REQ-009 SHALL have port: coef_ready  in  1  downstream accepts; transfer = coef_valid & coef_ready.
REQ-010 SHALL have port: coef_last  out  1  high with the 64th coef of a block.
REQ-011 SHALL have port: blk_done  out  1  one-cycle pulse: block slot released to writer.
REQ-012 SHALL have port: overflow  out  1  sticky: blk_valid arrived with 4 blocks pending.

Function
REQ-013 SHALL treat BRAM as a 4-block ring (256 x 12); blk_idx 2-bit, wraps 3->0.
REQ-014 SHALL keep pending counter 0..4: +1 on blk_valid, -1 on blk_done; both same cycle -> unchanged.
REQ-015 SHALL ignore blk_valid when pending==4 and set overflow until reset.
REQ-016 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-017 IDLE: pending>0 -> READ next edge, read index k=0.
REQ-018 READ: issue read (ce_BRAM_read=1) only when buffer_occupancy + inflight < 2; k increments per issued read; after k=63 issued -> DRAIN.
REQ-019 SHALL capture dout_BRAM into a 2-entry output FIFO the cycle after the read; coef_valid high the following cycle (read-to-valid latency 2).
REQ-020 SHALL sustain 1 coef/cycle with coef_ready constantly high; no coef lost or duplicated under any coef_ready pattern.
REQ-021 coef, coef_last SHALL remain stable while coef_valid & !coef_ready.
REQ-022 DRAIN: on transfer with coef_last -> blk_done pulse next cycle, blk_idx+1, IDLE; if pending-1>0, READ follows without extra idle cycle beyond IDLE.
REQ-023 ce_BRAM_read=0 in IDLE and DRAIN; addr_BRAM_read holds last value when not reading.

Reset
REQ-024 rst SHALL asynchronously clear: state=IDLE, k=0, blk_idx=0, pending=0, FIFO empty, inflight=0, overflow=0.
REQ-025 During rst all outputs SHALL be 0 (ce_BRAM_read, addr_BRAM_read, coef, coef_valid, coef_last, blk_done, overflow).
REQ-026 Reset mid-block SHALL discard the partial block; no blk_done for it.
REQ-027 First blk_valid SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro ZZ_REORDER_EN defined: pos = standard JPEG zig-zag table[k] (k=0->0, 1->1, 2->8, 3->16, 4->9, 5->2, 63->63), output in zig-zag order.
REQ-029 Macro ZZ_REORDER_EN undefined: pos = k (raster order); table not synthesised; all else identical.

Verification
REQ-030 Reset then one blk_valid, coef_ready=1, BRAM[i]=i -> ZZ_REORDER_EN: coef sequence 0,1,8,16,9,2..63; undefined: 0..63; coef_last on 64th; blk_done one cycle after.
REQ-031 Same, coef_ready toggling 1/0 each cycle -> identical 64-value sequence, stable while stalled, ce_BRAM_read never issued with 2 entries buffered/inflight.
REQ-032 Five blk_valid pulses before any read completes -> overflow=1, exactly 4 blocks streamed (addresses 0x00,0x40,0x80,0xC0 bases), overflow held.
REQ-033 blk_valid coinciding with blk_done at pending=1 -> pending stays 1, next block starts streaming, blk_idx=1.
REQ-034 rst asserted after 20 coefs transferred -> all outputs 0 asynchronously; after release, new blk_valid streams block 0 from k=0.
